// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants, conversion state type and segment decode for the score display
package score_pkg;

    localparam int MAX_SCORE = 99;

    localparam logic [0:9][6:0] SEG_LUT = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    // Nibbles above 9 cannot come out of the converter; decode them dark anyway.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        if (digit > 4'd9) begin
            seg = SEG_BLANK;
        end else begin
            seg = SEG_LUT[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter producing tens and units BCD digits
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int BW = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [BW-1:0] bin_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [3:0]    tens_o,
    output logic [3:0]    units_o
);

    localparam int SW = BW + 8;
    localparam int CW = $clog2(BW + 1);

    conv_state_t   state_q;
    conv_state_t   state_d;
    logic [SW-1:0] sr_q;
    logic [SW-1:0] sr_adj;
    logic [CW-1:0] cnt_q;
    logic [3:0]    units_nib;
    logic [3:0]    tens_nib;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
    end

    assign units_nib = sr_q[BW+3:BW];
    assign tens_nib  = sr_q[BW+7:BW+4];

    // Hundreds are not kept: anything above 99 is shown as dashes by the top.
    always_comb begin
        sr_adj = sr_q;
        if (units_nib >= 4'd5) sr_adj[BW+3:BW]   = units_nib + 4'd3;
        if (tens_nib >= 4'd5)  sr_adj[BW+7:BW+4] = tens_nib + 4'd3;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            tens_o  <= 4'd0;
            units_o <= 4'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    sr_q  <= {8'b0, bin_i};
                    cnt_q <= CW'(BW);
                end
                SHIFT: begin
                    sr_q  <= {sr_adj[SW-2:0], 1'b0};
                    cnt_q <= cnt_q - CW'(1);
                end
                DONE: begin
                    tens_o  <= tens_nib;
                    units_o <= units_nib;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - score to two-digit multiplexed 7-segment driver with overflow dashes
module score_display_driver
    import score_pkg::*;
#(
    parameter int BW          = 7,
    parameter int REFRESH_DIV = 1024,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic          ovf_o,
    output logic          busy_o
);

    localparam int RW = $clog2(REFRESH_DIV);

    logic [BW-1:0] last_q;
    logic          pending_q;
    logic          start;
    logic          conv_busy;
    logic          conv_done;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic          ovf_q;
    logic [RW-1:0] refresh_q;
    logic          refresh_wrap;
    logic [1:0]    dig_sel_d;
    logic [6:0]    seg_d;

    assign start = pending_q || (value_i != last_q);

    // The converter reads last_q, which is frozen for the whole conversion.
    bin2bcd_seq #(
        .BW(BW)
    ) u_conv (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start),
        .bin_i   (last_q),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .tens_o  (tens),
        .units_o (units)
    );

    assign busy_o = conv_busy;
    assign ovf_o  = ovf_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q    <= '0;
            pending_q <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            if (start && !conv_busy) begin
                last_q    <= value_i;
                pending_q <= 1'b0;
            end
            if (conv_done) begin
                ovf_q <= (int'(last_q) > MAX_SCORE);
            end
        end
    end

    assign refresh_wrap = (refresh_q == RW'(REFRESH_DIV - 1));

    always_comb begin
        dig_sel_d = dig_sel_o;
        if (dig_sel_o == 2'b00) begin
            dig_sel_d = 2'b01;
        end else if (refresh_wrap) begin
            dig_sel_d = {dig_sel_o[0], dig_sel_o[1]};
        end
    end

    always_comb begin
        seg_d = seg_decode(units);
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (dig_sel_d[1]) begin
            seg_d = (LZ_BLANK && tens == 4'd0) ? SEG_BLANK : seg_decode(tens);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            refresh_q <= '0;
            dig_sel_o <= 2'b00;
            seg_o     <= 7'h00;
        end else begin
            refresh_q <= refresh_wrap ? '0 : refresh_q + RW'(1);
            dig_sel_o <= dig_sel_d;
            seg_o     <= seg_d;
        end
    end

endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - scoreboard bench for score_display_driver
module tb_score_display_driver;

    logic       clk_i;
    logic       rst_i;
    logic [6:0] value_i;
    logic [6:0] seg_o;
    logic [1:0] dig_sel_o;
    logic       ovf_o;
    logic       busy_o;

    int total_checks  = 0;
    int passed_checks = 0;
    int seg_viol      = 0;
    int sel_viol      = 0;

    logic [14:0] exp_q[$];

    score_display_driver #(
        .BW          (7),
        .REFRESH_DIV (4),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .value_i   (value_i),
        .seg_o     (seg_o),
        .dig_sel_o (dig_sel_o),
        .ovf_o     (ovf_o),
        .busy_o    (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_model(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Entry layout: {ovf, units slot segments, tens slot segments}
    function automatic logic [14:0] expect_of(input int v);
        int u;
        int t;
        if (v > 99) return {1'b1, 7'h40, 7'h40};
        u = v % 10;
        t = v / 10;
        return {1'b0, seg_model(u), (t == 0) ? 7'h00 : seg_model(t)};
    endfunction

    task automatic apply(input int v);
        value_i = 7'(v);
        exp_q.push_back(expect_of(v));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk_i);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic collect();
        logic [6:0]  us;
        logic [6:0]  ts;
        logic        ov;
        bit          gu;
        bit          gt;
        logic [14:0] e;
        us = 'x;
        ts = 'x;
        gu = 1'b0;
        gt = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 12 && !(gu && gt); i++) begin
            if (dig_sel_o == 2'b01 && !gu) begin us = seg_o; gu = 1'b1; end
            if (dig_sel_o == 2'b10 && !gt) begin ts = seg_o; gt = 1'b1; end
            if (!(gu && gt)) @(negedge clk_i);
        end
        ov = ovf_o;
        check("slots_seen", {30'd0, gu, gt}, 32'd3);
        check("expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("units_seg", us, e[13:7]);
            check("tens_seg", ts, e[6:0]);
            check("ovf", ov, e[14]);
        end
    endtask

    // Conversion monitor: a busy fall outside reset means new digits were latched.
    initial begin
        logic bp;
        bp = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i && bp && !busy_o) collect();
            bp = busy_o && rst_i;
        end
    end

    // seg_o may change only with dig_sel_o or on the cycle after a conversion lands.
    initial begin
        logic [6:0] ps;
        logic [1:0] pd;
        logic       pb;
        logic       fell;
        int         since_rst;
        ps = '0; pd = '0; pb = 1'b0; fell = 1'b0; since_rst = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                since_rst = 0;
            end else begin
                since_rst++;
                if (since_rst > 2) begin
                    if (seg_o != ps && dig_sel_o == pd && !fell) seg_viol++;
                    if (dig_sel_o != 2'b01 && dig_sel_o != 2'b10) sel_viol++;
                end
            end
            fell = rst_i && pb && !busy_o;
            pb   = busy_o;
            ps   = seg_o;
            pd   = dig_sel_o;
        end
    end

    initial begin
        int n;
        logic [1:0] last_sel;
        rst_i   = 1'b0;
        value_i = 7'd0;
        repeat (3) @(negedge clk_i);
        check("rst_seg", seg_o, 0);
        check("rst_sel", dig_sel_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_busy", busy_o, 0);
        exp_q.push_back(expect_of(0));
        rst_i = 1'b1;
        drain();

        apply(42);
        for (int i = 0; i < 5 && !busy_o; i++) @(negedge clk_i);
        n = 0;
        while (busy_o && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        check("busy_cycles", n, 9);
        drain();

        apply(99);
        drain();
        apply(100);
        drain();
        apply(7);
        drain();

        apply(17);
        for (int i = 0; i < 5 && !busy_o; i++) @(negedge clk_i);
        @(negedge clk_i);
        apply(58);
        drain();

        for (int i = 0; i < 10 && dig_sel_o == dig_sel_o; i++) begin
            last_sel = dig_sel_o;
            @(negedge clk_i);
            if (dig_sel_o != last_sel) break;
        end
        for (int k = 0; k < 3; k++) begin
            last_sel = dig_sel_o;
            n = 0;
            while (dig_sel_o == last_sel && n < 20) begin
                n++;
                @(negedge clk_i);
            end
            check("refresh_period", n, 4);
        end

        apply(100);
        drain();
        value_i = 7'd33;
        for (int i = 0; i < 5 && !busy_o; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("async_seg", seg_o, 0);
        check("async_sel", dig_sel_o, 0);
        check("async_ovf", ovf_o, 0);
        check("async_busy", busy_o, 0);
        @(negedge clk_i);
        exp_q.push_back(expect_of(33));
        rst_i = 1'b1;
        drain();
        repeat (4) @(negedge clk_i);

        check("seg_stability", seg_viol, 0);
        check("sel_onehot", sel_viol, 0);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
